// File: rtl/axis_loopback_responder.sv
// AXI-Stream loopback responder: buffers accepted beats in a FIFO and echoes them
// back to the sender, with the reply tdest taken from the original tid.
// Latency: at least one cycle; output is driven only from registered FIFO state.
// Backpressure: in_tready drops when the FIFO is full or when a new packet is refused.
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   enable            admit new packets (a packet already in progress always completes)
//   axis_in_*         AXI-Stream sink from the NoC
//   axis_out_*        AXI-Stream echo source to the NoC
//   echoed_packets    count of fully retransmitted packets (wraps)
//   misroute_error    sticky: a beat arrived whose tdest was not NODE_ID
//   occupancy         beats currently buffered
module axis_loopback_responder #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int COUNT_WIDTH = 32,
    parameter int NODE_ID     = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          axis_in_tvalid,
    output logic                          axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]        axis_in_tdata,
    input  logic                          axis_in_tlast,
    input  logic [TID_WIDTH-1:0]          axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]        axis_in_tdest,
    output logic                          axis_out_tvalid,
    input  logic                          axis_out_tready,
    output logic [TDATA_WIDTH-1:0]        axis_out_tdata,
    output logic                          axis_out_tlast,
    output logic [TID_WIDTH-1:0]          axis_out_tid,
    output logic [TDEST_WIDTH-1:0]        axis_out_tdest,
    output logic [COUNT_WIDTH-1:0]        echoed_packets,
    output logic                          misroute_error,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = TDATA_WIDTH + 1 + TID_WIDTH;
    localparam logic [OCC_W-1:0]       DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [TDEST_WIDTH-1:0] MY_DEST   = TDEST_WIDTH'(NODE_ID);
    localparam logic [TID_WIDTH-1:0]   MY_ID     = TID_WIDTH'(NODE_ID);

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [COUNT_WIDTH-1:0] echoed_q, echoed_d;
    logic                   misroute_q, misroute_d;

    // Entry layout: {tdata, tlast, tid}; tdest is checked on entry but not kept.
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     head;

    logic push;
    logic pop;

    // Gating with rst_n keeps both handshakes quiet while reset is held, even
    // before the first reset edge has cleared the state.
    assign axis_in_tready  = rst_n && (enable || (state_q == ST_IN_PKT)) && (occ_q < DEPTH_OCC);
    assign axis_out_tvalid = rst_n && (occ_q != '0);

    assign push = axis_in_tvalid && axis_in_tready;
    assign pop  = axis_out_tvalid && axis_out_tready;

    assign head           = mem_q[rd_ptr_q];
    assign axis_out_tdata = head[ENTRY_W-1 -: TDATA_WIDTH];
    assign axis_out_tlast = head[TID_WIDTH];
    assign axis_out_tdest = head[TID_WIDTH-1:0];
    assign axis_out_tid   = MY_ID;

    assign echoed_packets = echoed_q;
    assign misroute_error = misroute_q;
    assign occupancy      = occ_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        echoed_d   = echoed_q;
        misroute_d = misroute_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            state_d  = axis_in_tlast ? ST_IDLE : ST_IN_PKT;
            if (axis_in_tdest != MY_DEST) begin
                misroute_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (axis_out_tlast) begin
                echoed_d = echoed_q + COUNT_WIDTH'(1);
            end
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            echoed_q   <= '0;
            misroute_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            echoed_q   <= echoed_d;
            misroute_q <= misroute_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {axis_in_tdata, axis_in_tlast, axis_in_tid};
        end
    end

endmodule

// File: tb/tb_axis_loopback_responder.sv
module tb_axis_loopback_responder;

    localparam int NODE     = 2;
    localparam int DEPTH    = 8;
    localparam int N_STRESS = 16384;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        in_tvalid;
    logic        in_tready;
    logic [63:0] in_tdata;
    logic        in_tlast;
    logic [1:0]  in_tid;
    logic [1:0]  in_tdest;
    logic        out_tvalid;
    logic        out_tready;
    logic [63:0] out_tdata;
    logic        out_tlast;
    logic [1:0]  out_tid;
    logic [1:0]  out_tdest;
    logic [31:0] echoed;
    logic        misroute;
    logic [3:0]  occupancy;

    axis_loopback_responder #(
        .TDATA_WIDTH(64),
        .TDEST_WIDTH(2),
        .TID_WIDTH  (2),
        .COUNT_WIDTH(32),
        .NODE_ID    (NODE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .axis_in_tvalid (in_tvalid),
        .axis_in_tready (in_tready),
        .axis_in_tdata  (in_tdata),
        .axis_in_tlast  (in_tlast),
        .axis_in_tid    (in_tid),
        .axis_in_tdest  (in_tdest),
        .axis_out_tvalid(out_tvalid),
        .axis_out_tready(out_tready),
        .axis_out_tdata (out_tdata),
        .axis_out_tlast (out_tlast),
        .axis_out_tid   (out_tid),
        .axis_out_tdest (out_tdest),
        .echoed_packets (echoed),
        .misroute_error (misroute),
        .occupancy      (occupancy)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  id;
        logic [1:0]  dest;
    } beat_t;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [1:0]  id;
        logic [1:0]  dst;
        logic [31:0] exp_echo;
        logic        exp_mis;
    } vec_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    stress_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #(98000 * 10);
        $display("FAIL watchdog: simulation did not finish, time %0t required < %0t", $time, 98000 * 10);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT, got no event expected one", name);
    endtask

    // Scoreboard: expectation recorded on each input handshake, checked on each output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_tvalid && out_tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", out_tdata);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("echo_beat", 128'({out_tdata, out_tlast, out_tid, out_tdest}), 128'(e));
                end
            end
            if (in_tvalid && in_tready) begin
                beat_t e;
                e.data = in_tdata;
                e.last = in_tlast;
                e.id   = 2'(NODE);
                e.dest = in_tid;
                sb.push_back(e);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send_beat(input logic [63:0] d, input logic l, input logic [1:0] id,
                             input logic [1:0] dst, input bit rnd);
        int  n    = 0;
        bit  done = 0;
        in_tdata = d;
        in_tlast = l;
        in_tid   = id;
        in_tdest = dst;
        while (!done) begin
            in_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_tvalid && in_tready) done = 1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 2000) begin
                fail_timeout("accept_beat");
                done = 1;
            end
        end
        in_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || occupancy != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) fail_timeout(name);
    endtask

    initial begin
        vec_t vecs[8];
        bit   bad;

        vecs[0] = '{64'h0000_0000_DEAD_BEEF, 1'b1, 2'd1, 2'd2, 32'd1, 1'b0};
        vecs[1] = '{64'h0000_0000_0000_0000, 1'b1, 2'd0, 2'd2, 32'd2, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd3, 2'd2, 32'd2, 1'b0};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 1'b1, 2'd3, 2'd2, 32'd3, 1'b0};
        vecs[4] = '{64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 2'd2, 2'd2, 32'd4, 1'b0};
        vecs[5] = '{64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 2'd0, 2'd3, 32'd5, 1'b1};
        vecs[6] = '{64'h1111_2222_3333_4444, 1'b1, 2'd1, 2'd2, 32'd6, 1'b1};
        vecs[7] = '{64'h8000_0000_0000_0001, 1'b1, 2'd2, 2'd0, 32'd7, 1'b1};

        rst_n       = 1'b0;
        enable      = 1'b1;
        in_tvalid   = 1'b0;
        in_tdata    = '0;
        in_tlast    = 1'b0;
        in_tid      = '0;
        in_tdest    = '0;
        out_tready  = 1'b1;
        stress_done = 1'b0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_tready", 128'(in_tready), 128'(0));
        check("rst_out_tvalid", 128'(out_tvalid), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_tready", 128'(in_tready), 128'(enable));
        check("post_rst_occupancy", 128'(occupancy), 128'(0));
        check("post_rst_echoed", 128'(echoed), 128'(0));
        check("post_rst_misroute", 128'(misroute), 128'(0));
        @(posedge clk);
        #1;

        // Vector table: single beats and a 2-beat packet, misroute rows last (flag is sticky)
        for (int i = 0; i < 8; i++) begin
            send_beat(vecs[i].d, vecs[i].l, vecs[i].id, vecs[i].dst, 1'b0);
            wait_drain("vec_drain");
            check("vec_echoed", 128'(echoed), 128'(vecs[i].exp_echo));
            check("vec_misroute", 128'(misroute), 128'(vecs[i].exp_mis));
        end

        // Latency: no combinational path, beat visible the cycle after acceptance
        out_tready = 1'b0;
        in_tdata   = 64'hCAFE_F00D_0000_0042;
        in_tlast   = 1'b1;
        in_tid     = 2'd3;
        in_tdest   = 2'd2;
        in_tvalid  = 1'b1;
        @(negedge clk);
        check("lat_in_tready", 128'(in_tready), 128'(1));
        check("lat_no_comb_path", 128'(out_tvalid), 128'(0));
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        @(negedge clk);
        check("lat_out_tvalid", 128'(out_tvalid), 128'(1));
        check("lat_occupancy", 128'(occupancy), 128'(1));
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        wait_drain("lat_drain");
        check("lat_echoed", 128'(echoed), 128'(8));

        // Backpressure fill: 10-beat packet into an 8-deep FIFO with output stalled
        out_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_beat(64'h1000 + 64'(i), (i == 9), 2'd1, 2'd2, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (occupancy != 4'(DEPTH) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_full_occupancy", 128'(occupancy), 128'(DEPTH));
                check("bp_full_in_tready", 128'(in_tready), 128'(0));
                repeat (3) @(negedge clk);
                check("bp_hold_occupancy", 128'(occupancy), 128'(DEPTH));
                @(posedge clk);
                #1;
                out_tready = 1'b1;
                @(negedge clk);
                check("bp_pop_cycle_in_tready", 128'(in_tready), 128'(0));
            end
        join
        wait_drain("bp_drain");
        check("bp_echoed", 128'(echoed), 128'(9));

        // Enable dropped mid-packet: packet completes, then new packets are refused
        send_beat(64'h2001, 1'b0, 2'd0, 2'd2, 1'b0);
        send_beat(64'h2002, 1'b0, 2'd0, 2'd2, 1'b0);
        enable = 1'b0;
        send_beat(64'h2003, 1'b0, 2'd0, 2'd2, 1'b0);
        send_beat(64'h2004, 1'b1, 2'd0, 2'd2, 1'b0);
        @(negedge clk);
        check("en_off_in_tready", 128'(in_tready), 128'(0));
        @(posedge clk);
        #1;
        in_tdata  = 64'h3001;
        in_tlast  = 1'b1;
        in_tid    = 2'd1;
        in_tdest  = 2'd2;
        in_tvalid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_tready) bad = 1;
            @(posedge clk);
            #1;
        end
        check("en_off_refused", 128'(bad), 128'(0));
        enable = 1'b1;
        send_beat(64'h3001, 1'b1, 2'd1, 2'd2, 1'b0);
        wait_drain("en_drain");
        check("en_echoed", 128'(echoed), 128'(11));

        // Reset with a partial packet buffered
        out_tready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_beat(64'h4000 + 64'(i), 1'b0, 2'd2, 2'd2, 1'b0);
        @(negedge clk);
        check("rst_mid_occupancy_before", 128'(occupancy), 128'(5));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_mid_in_tready", 128'(in_tready), 128'(0));
        check("rst_mid_out_tvalid", 128'(out_tvalid), 128'(0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_occupancy", 128'(occupancy), 128'(0));
        check("rst_mid_echoed", 128'(echoed), 128'(0));
        check("rst_mid_misroute", 128'(misroute), 128'(0));
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_tvalid) bad = 1;
            @(posedge clk);
            #1;
        end
        check("rst_mid_no_stale", 128'(bad), 128'(0));

        // Random stress: random lengths, random tvalid and tready
        fork
            begin
                for (int p = 0; p < N_STRESS; p++) begin
                    int len;
                    len = $urandom_range(1, 2);
                    for (int b = 0; b < len; b++)
                        send_beat({$urandom(), $urandom()}, (b == len - 1),
                                  2'($urandom_range(0, 3)), 2'(NODE), 1'b1);
                end
                stress_done = 1'b1;
            end
            begin
                while (!stress_done) begin
                    @(posedge clk);
                    #1;
                    out_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_tready = 1'b1;
        wait_drain("stress_drain");
        check("stress_echoed", 128'(echoed), 128'(N_STRESS));
        check("stress_sb_empty", 128'(sb.size()), 128'(0));
        check("stress_misroute", 128'(misroute), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
